fc_weight_sched: RTL and testbench
==================================

# fc_weight_sched

Sequencer for one fully-connected pass: on a start pulse it walks every (input, output) pair, issuing one weight-memory read per cycle, and delays the read strobe and index by the memory's one-cycle read latency to drive the accumulator bank. Each weight-memory read advances the weight counter by exactly one, so the counter steps through outputs 0..OUTPUT_NUM-1 once per input. This block sits between the layer-level controller (start/done) and the weight memory, its weight counter and the per-output accumulators.

## Interface
- OUTPUT_NUM, 14: output neurons; the weight index wraps at OUTPUT_NUM-1
- INPUT_NUM, 10: input activations per pass
- MEM_ADDR, 4: width of the weight index; OUTPUT_NUM <= 2^MEM_ADDR
- IN_ADDR, 4: width of the input address; INPUT_NUM <= 2^IN_ADDR

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- hold  in  1  stall; freezes the sequencer while in RUN
- abort  in  1  synchronous cancel of the current pass
- rd_en  out  1  weight read strobe; same signal that advances the weight counter
- w_idx  out  MEM_ADDR  weight index of the read issued this cycle
- in_addr  out  IN_ADDR  input activation address of the read issued this cycle
- acc_en  out  1  accumulator write strobe; rd_en delayed 1 cycle
- acc_idx  out  MEM_ADDR  accumulator index; w_idx delayed 1 cycle
- acc_load  out  1  with acc_en: load the product (first input) instead of adding it
- busy  out  1  high in RUN, DRAIN and DONE
- done  out  1  one-cycle pulse at the end of a completed pass

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN. Clear w_idx and in_addr to 0. hold is ignored.
- RUN:
  - rd_en = ~hold (combinational).
  - Each cycle with rd_en=1: if w_idx==OUTPUT_NUM-1, set w_idx to 0 and increment in_addr; otherwise increment w_idx.
  - When w_idx==OUTPUT_NUM-1, in_addr==INPUT_NUM-1 and rd_en=1: go to DRAIN. in_addr does not increment on this read.
  - hold=1: rd_en=0 and both indices freeze.
- DRAIN: one cycle, rd_en=0, -> DONE.
- DONE: done=1 for one cycle, -> IDLE.
- Accumulator delay stage:
  - Registered every cycle: acc_en <= rd_en, acc_idx <= w_idx, acc_load <= rd_en & (in_addr==0).
  - acc_load marks the first input, so the accumulators need no separate clear.
- start while busy: ignored; a pass is never restarted or queued.
- abort=1 in RUN, DRAIN or DONE: next state IDLE, indices cleared, no done pulse.
  - In the abort cycle rd_en follows the normal rule (~hold in RUN); that read's acc_en still appears one cycle later.
- abort and start together in IDLE: abort wins and the block stays in IDLE.
- Counter arithmetic: unsigned. w_idx never exceeds OUTPUT_NUM-1 and in_addr never exceeds INPUT_NUM-1.
- Reset (async, any state): state IDLE; rd_en, acc_en, acc_load, busy and done = 0; w_idx, in_addr and acc_idx = 0.

## Timing
- Start sampled at edge E0; rd_en is high from the cycle after E0.
- With no hold:
  - Reads occupy OUTPUT_NUM*INPUT_NUM consecutive cycles (140 by default): cycles 1..140.
  - acc_en is high in cycles 2..141; DRAIN is cycle 141.
  - done is high in cycle 142; IDLE from cycle 143; busy is high in cycles 1..142.
- Each hold cycle in RUN adds exactly one cycle to every later event.
- Latency from a read to its accumulator write is fixed at 1 cycle, including across hold.
- Earliest next start: the IDLE cycle right after done (back-to-back passes with one idle cycle between).

## Test plan
- Nominal pass: start pulse with defaults, no hold -> exactly 140 rd_en cycles; w_idx runs 0..13 ten times; in_addr runs 0..9; done single pulse at cycle 142; busy falls at cycle 143.
- acc_load check: acc_load=1 on exactly the first 14 acc_en cycles (acc_idx 0..13) and 0 for the remaining 126; acc_idx sequence equals w_idx delayed by 1.
- Hold: hold=1 for 3 cycles at w_idx=13, in_addr=4 -> rd_en=0 and indices frozen during the hold; the wrap to w_idx=0, in_addr=5 happens on the first read after release; done arrives at cycle 145.
- Abort: abort at in_addr=2, w_idx=6 -> IDLE next cycle, no done; a following start gives a full 140-read pass starting from w_idx=0, in_addr=0.
- Start while busy / start+abort in IDLE: start pulses mid-pass cause no disturbance and exactly one done; start and abort together in IDLE -> stays IDLE, rd_en stays 0.
- Async reset mid-pass: reset low at in_addr=7 -> all outputs 0 immediately, without waiting for a clock edge; after release the block waits in IDLE until start.

Source files
------------

// File: rtl/fc_weight_sched_if.sv
// ---------------------------------------------------------------------------
// fc_weight_sched_if
//
// Purpose:
//   Bundles the control and datapath strobes exchanged between the
//   fully-connected weight sequencer and its neighbours. These are the
//   layer controller (start/hold/abort/busy/done), the weight memory and
//   weight counter (rd_en/w_idx/in_addr), and the accumulator bank
//   (acc_en/acc_idx/acc_load).
//
// Parameters:
//   MEM_ADDR - width of the weight / accumulator index
//   IN_ADDR  - width of the input activation address
//
// Signals:
//   start    - begin a pass (sampled only while idle)
//   hold     - stall request; freezes the sequencer while it is reading
//   abort    - synchronous cancel of the current pass
//   rd_en    - weight read strobe; also advances the weight counter
//   w_idx    - weight index of the read issued this cycle
//   in_addr  - input activation address of the read issued this cycle
//   acc_en   - accumulator write strobe (rd_en delayed one cycle)
//   acc_idx  - accumulator index (w_idx delayed one cycle)
//   acc_load - with acc_en: load the product instead of adding it
//   busy     - a pass is in progress
//   done     - one-cycle pulse when a pass completes
//
// Modports:
//   master - the side that requests passes and consumes the strobes
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface fc_weight_sched_if #(
  parameter int MEM_ADDR = 4,
  parameter int IN_ADDR  = 4
);

  logic                start;
  logic                hold;
  logic                abort;
  logic                rd_en;
  logic [MEM_ADDR-1:0] w_idx;
  logic [IN_ADDR-1:0]  in_addr;
  logic                acc_en;
  logic [MEM_ADDR-1:0] acc_idx;
  logic                acc_load;
  logic                busy;
  logic                done;

  modport master (
    output start,
    output hold,
    output abort,
    input  rd_en,
    input  w_idx,
    input  in_addr,
    input  acc_en,
    input  acc_idx,
    input  acc_load,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  hold,
    input  abort,
    output rd_en,
    output w_idx,
    output in_addr,
    output acc_en,
    output acc_idx,
    output acc_load,
    output busy,
    output done
  );

endinterface

// File: rtl/fc_weight_sched.sv
// ---------------------------------------------------------------------------
// fc_weight_sched
//
// Purpose:
//   Sequencer for one fully-connected pass. A start pulse makes it walk every
//   (input, output) pair and issue one weight-memory read per cycle. The
//   output index runs fastest, and the input address steps each time the
//   output index wraps. The read strobe and index are delayed by the
//   memory's one-cycle read latency so that they drive the accumulator bank.
//
// Parameters:
//   OUTPUT_NUM - number of output neurons (weight index wraps at OUTPUT_NUM-1)
//   INPUT_NUM  - number of input activations per pass
//   MEM_ADDR   - width of the weight index   (OUTPUT_NUM <= 2**MEM_ADDR)
//   IN_ADDR    - width of the input address  (INPUT_NUM  <= 2**IN_ADDR)
//
// Ports:
//   clk   - single clock, rising-edge
//   reset - asynchronous, active-low reset
//   bus   - fc_weight_sched_if.slave:
//           in : start, hold, abort
//           out: rd_en, w_idx, in_addr, acc_en, acc_idx, acc_load, busy, done
// ---------------------------------------------------------------------------
module fc_weight_sched #(
  parameter int OUTPUT_NUM = 14,
  parameter int INPUT_NUM  = 10,
  parameter int MEM_ADDR   = 4,
  parameter int IN_ADDR    = 4
) (
  input  logic              clk,
  input  logic              reset,
  fc_weight_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [MEM_ADDR-1:0] W_LAST  = MEM_ADDR'(OUTPUT_NUM - 1);
  localparam logic [IN_ADDR-1:0]  IN_LAST = IN_ADDR'(INPUT_NUM - 1);

  state_t              state_q;
  state_t              state_d;

  logic [MEM_ADDR-1:0] w_idx_q;
  logic [MEM_ADDR-1:0] w_idx_d;
  logic [IN_ADDR-1:0]  in_addr_q;
  logic [IN_ADDR-1:0]  in_addr_d;

  logic                acc_en_q;
  logic [MEM_ADDR-1:0] acc_idx_q;
  logic                acc_load_q;

  logic                rd_en_c;
  logic                busy_c;
  logic                done_c;

  logic                last_w;
  logic                last_in;
  logic                last_read;

  // Position flags for the read being issued this cycle. last_read is the
  // final (input, output) pair, which ends the reading phase of the pass.
  assign last_w    = (w_idx_q == W_LAST);
  assign last_in   = (in_addr_q == IN_LAST);
  assign last_read = rd_en_c & last_w & last_in;

  // State register. The asynchronous reset drops the sequencer straight
  // back to IDLE. Every output is derived from IDLE or held in a register
  // that is cleared here, so all outputs go to 0 without waiting for a
  // clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. abort takes priority over everything, including a
  // start that arrives in the same IDLE cycle. start is looked at only in
  // IDLE, so a pass is never restarted or queued. DRAIN is the cycle in
  // which the last read's accumulator write lands.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_read) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State-decoded outputs. rd_en is combinational on hold, so a stall takes
  // effect in the same cycle it is asserted. An abort that lands in the
  // DONE cycle suppresses the done pulse, because that pass is being
  // cancelled.
  always_comb begin
    rd_en_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd_en_c = 1'b0;
        busy_c  = 1'b0;
      end
      RUN: begin
        rd_en_c = ~bus.hold;
        busy_c  = 1'b1;
      end
      DRAIN: begin
        busy_c  = 1'b1;
      end
      DONE: begin
        busy_c  = 1'b1;
        done_c  = ~bus.abort;
      end
      default: begin
        rd_en_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
      end
    endcase
  end

  // Index counters. They move only on a read. The output index wraps at
  // OUTPUT_NUM-1 and carries into the input address. The carry is
  // suppressed on the final read, so in_addr never exceeds INPUT_NUM-1.
  // Outside RUN, or on abort, both indices are cleared. This means every
  // pass starts from (0, 0) without needing any extra bookkeeping.
  always_comb begin
    w_idx_d   = w_idx_q;
    in_addr_d = in_addr_q;
    if (state_q != RUN || bus.abort) begin
      w_idx_d   = '0;
      in_addr_d = '0;
    end else if (rd_en_c) begin
      if (last_w) begin
        w_idx_d = '0;
        if (!last_in) begin
          in_addr_d = in_addr_q + IN_ADDR'(1);
        end
      end else begin
        w_idx_d = w_idx_q + MEM_ADDR'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_idx_q   <= '0;
      in_addr_q <= '0;
    end else begin
      w_idx_q   <= w_idx_d;
      in_addr_q <= in_addr_d;
    end
  end

  // Accumulator delay stage. This register matches the weight memory's
  // one-cycle read latency. It runs every cycle with no stall input, so
  // the read-to-write distance stays exactly one cycle even across hold
  // and abort. acc_load flags the first input, so each accumulator
  // overwrites its stale value instead of needing a separate clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_en_q   <= 1'b0;
      acc_idx_q  <= '0;
      acc_load_q <= 1'b0;
    end else begin
      acc_en_q   <= rd_en_c;
      acc_idx_q  <= w_idx_q;
      acc_load_q <= rd_en_c & (in_addr_q == '0);
    end
  end

  assign bus.rd_en    = rd_en_c;
  assign bus.w_idx    = w_idx_q;
  assign bus.in_addr  = in_addr_q;
  assign bus.acc_en   = acc_en_q;
  assign bus.acc_idx  = acc_idx_q;
  assign bus.acc_load = acc_load_q;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;

endmodule

// File: tb/tb_fc_weight_sched.sv
// ---------------------------------------------------------------------------
// tb_fc_weight_sched
//
// Purpose:
//   Self-checking bench for fc_weight_sched with default parameters
//   (14 outputs x 10 inputs). Directed steps are run in one initial block.
//   Inputs are driven and outputs are sampled on the falling clock edge.
//   Cycle numbers in the comments count from the rising edge that samples
//   start (cycle 1 = first read).
// ---------------------------------------------------------------------------
module tb_fc_weight_sched;

  localparam int OUTPUT_NUM = 14;
  localparam int INPUT_NUM  = 10;
  localparam int MEM_ADDR   = 4;
  localparam int IN_ADDR    = 4;

  logic clk;
  logic reset;

  int tests;
  int fails;

  fc_weight_sched_if #(.MEM_ADDR(MEM_ADDR), .IN_ADDR(IN_ADDR)) bus ();

  fc_weight_sched #(
    .OUTPUT_NUM (OUTPUT_NUM),
    .INPUT_NUM  (INPUT_NUM),
    .MEM_ADDR   (MEM_ADDR),
    .IN_ADDR    (IN_ADDR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the three control inputs together.
  task automatic apply_stimulus(input logic s, input logic h, input logic a);
    bus.start = s;
    bus.hold  = h;
    bus.abort = a;
  endtask

  // One comparison point: count it and report any difference.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Every output of the block at its reset/idle value.
  task automatic check_all_zero(input string tag);
    check_output({tag, ".rd_en"},    32'(bus.rd_en),    0);
    check_output({tag, ".w_idx"},    32'(bus.w_idx),    0);
    check_output({tag, ".in_addr"},  32'(bus.in_addr),  0);
    check_output({tag, ".acc_en"},   32'(bus.acc_en),   0);
    check_output({tag, ".acc_idx"},  32'(bus.acc_idx),  0);
    check_output({tag, ".acc_load"}, 32'(bus.acc_load), 0);
    check_output({tag, ".busy"},     32'(bus.busy),     0);
    check_output({tag, ".done"},     32'(bus.done),     0);
  endtask

  initial begin
    int done_cyc;
    int reads;
    int dones;
    int busy_fall;

    tests = 0;
    fails = 0;
    apply_stimulus(1'b0, 1'b0, 1'b0);

    // ---- Reset state ----
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    check_all_zero("idle_after_reset");

    // ---- Nominal pass ----
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 140; c++) begin
      check_output("nom.rd_en",   32'(bus.rd_en),   1);
      check_output("nom.w_idx",   32'(bus.w_idx),   (c - 1) % 14);
      check_output("nom.in_addr", 32'(bus.in_addr), (c - 1) / 14);
      check_output("nom.acc_en",  32'(bus.acc_en),  32'(c >= 2));
      if (c >= 2) begin
        check_output("nom.acc_idx",  32'(bus.acc_idx),  (c - 2) % 14);
        check_output("nom.acc_load", 32'(bus.acc_load), 32'((c - 2) < 14));
      end
      check_output("nom.busy", 32'(bus.busy), 1);
      check_output("nom.done", 32'(bus.done), 0);
      next_cycle();
    end
    // cycle 141: DRAIN carries the last accumulator write
    check_output("drain.rd_en",    32'(bus.rd_en),    0);
    check_output("drain.acc_en",   32'(bus.acc_en),   1);
    check_output("drain.acc_idx",  32'(bus.acc_idx),  13);
    check_output("drain.acc_load", 32'(bus.acc_load), 0);
    check_output("drain.busy",     32'(bus.busy),     1);
    check_output("drain.done",     32'(bus.done),     0);
    next_cycle();
    // cycle 142: DONE
    check_output("done.done",   32'(bus.done),   1);
    check_output("done.busy",   32'(bus.busy),   1);
    check_output("done.acc_en", 32'(bus.acc_en), 0);
    next_cycle();
    // cycle 143: back in IDLE
    check_all_zero("post_nom");

    // ---- Hold for 3 cycles at w_idx=13, in_addr=4 (cycles 70..72) ----
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    repeat (69) next_cycle();
    check_output("hold.pre_w",   32'(bus.w_idx),   13);
    check_output("hold.pre_in",  32'(bus.in_addr), 4);
    check_output("hold.pre_rd",  32'(bus.rd_en),   1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    #1 check_output("hold.rd_comb", 32'(bus.rd_en), 0);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      check_output("hold.rd_en",   32'(bus.rd_en),   0);
      check_output("hold.w_idx",   32'(bus.w_idx),   13);
      check_output("hold.in_addr", 32'(bus.in_addr), 4);
      check_output("hold.acc_en",  32'(bus.acc_en),  0);
    end
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    #1;
    check_output("rel.rd_en",   32'(bus.rd_en),   1);
    check_output("rel.w_idx",   32'(bus.w_idx),   13);
    check_output("rel.in_addr", 32'(bus.in_addr), 4);
    next_cycle();
    check_output("wrap.w_idx",   32'(bus.w_idx),   0);
    check_output("wrap.in_addr", 32'(bus.in_addr), 5);
    check_output("wrap.acc_en",  32'(bus.acc_en),  1);
    check_output("wrap.acc_idx", 32'(bus.acc_idx), 13);
    done_cyc = -1;
    for (int c = 74; c <= 220; c++) begin
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      next_cycle();
    end
    check_output("hold.done_cycle", done_cyc, 145);
    next_cycle();
    check_output("hold.busy_after", 32'(bus.busy), 0);

    // ---- Back-to-back start, then abort at in_addr=2, w_idx=6 ----
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("b2b.rd_en", 32'(bus.rd_en), 1);
    check_output("b2b.w_idx", 32'(bus.w_idx), 0);
    repeat (34) next_cycle();
    check_output("abort.pre_w",  32'(bus.w_idx),   6);
    check_output("abort.pre_in", 32'(bus.in_addr), 2);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    #1 check_output("abort.rd_en", 32'(bus.rd_en), 1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("abort.busy",    32'(bus.busy),    0);
    check_output("abort.rd_next", 32'(bus.rd_en),   0);
    check_output("abort.w_idx",   32'(bus.w_idx),   0);
    check_output("abort.in_addr", 32'(bus.in_addr), 0);
    check_output("abort.acc_en",  32'(bus.acc_en),  1);
    check_output("abort.acc_idx", 32'(bus.acc_idx), 6);
    dones = 0;
    repeat (5) begin
      next_cycle();
      if (bus.done === 1'b1) dones++;
    end
    check_output("abort.no_done", dones, 0);

    // ---- Full pass after abort, with start pulses while busy ----
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();
    reads     = 0;
    dones     = 0;
    done_cyc  = -1;
    busy_fall = -1;
    for (int c = 1; c <= 160; c++) begin
      apply_stimulus((c == 20 || c == 141 || c == 142), 1'b0, 1'b0);
      if (c == 1) begin
        check_output("pass2.first_w",  32'(bus.w_idx),   0);
        check_output("pass2.first_in", 32'(bus.in_addr), 0);
      end
      if (bus.rd_en === 1'b1) reads++;
      if (bus.done === 1'b1) begin
        dones++;
        done_cyc = c;
      end
      if (busy_fall < 0 && bus.busy === 1'b0) busy_fall = c;
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("pass2.reads",     reads,     140);
    check_output("pass2.dones",     dones,     1);
    check_output("pass2.done_cyc",  done_cyc,  142);
    check_output("pass2.busy_fall", busy_fall, 143);

    // ---- start and abort together in IDLE ----
    apply_stimulus(1'b1, 1'b0, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("sa.busy",  32'(bus.busy),  0);
    check_output("sa.rd_en", 32'(bus.rd_en), 0);
    next_cycle();
    check_output("sa.rd_en2", 32'(bus.rd_en), 0);

    // ---- Async reset mid-pass at in_addr=7 ----
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    repeat (98) next_cycle();
    check_output("rst.pre_in",  32'(bus.in_addr), 7);
    check_output("rst.pre_acc", 32'(bus.acc_en),  1);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    next_cycle();
    reset = 1'b1;
    repeat (4) begin
      next_cycle();
      check_output("rst.idle_busy", 32'(bus.busy),  0);
      check_output("rst.idle_rd",   32'(bus.rd_en), 0);
    end
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("rst.restart_rd", 32'(bus.rd_en),   1);
    check_output("rst.restart_w",  32'(bus.w_idx),   0);
    check_output("rst.restart_in", 32'(bus.in_addr), 0);
    done_cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      next_cycle();
    end
    check_output("rst.done_cycle", done_cyc, 142);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
